// File: rtl/hazard_sequencer.sv
// LC-3b pipeline hazard controller: load-use, control-transfer shadow and late-writeback bubbles.
// Optional saturating perf counters are built when HAZARD_PERF_EN is defined.
`timescale 1ns/1ps
module hazard_sequencer #(
    parameter int REG_IDX_W        = 3,
    parameter int NUM_REGS         = 8,
    parameter int BRANCH_SHADOW    = 4,
    parameter int LOAD_USE_BUBBLES = 1,
    parameter int LATE_LAT         = 2,
    parameter int PERF_W           = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flow,
    input  logic                 id_valid,
    input  logic                 id_sr1_v,
    input  logic                 id_sr2_v,
    input  logic                 id_sr3_v,
    input  logic [REG_IDX_W-1:0] id_sr1,
    input  logic [REG_IDX_W-1:0] id_sr2,
    input  logic [REG_IDX_W-1:0] id_sr3,
    input  logic                 id_ctrl_xfer,
    input  logic                 id_is_br,
    input  logic                 id_late_wr,
    input  logic [REG_IDX_W-1:0] id_dr,
    input  logic                 ex_load,
    input  logic                 ex_dr_v,
    input  logic [REG_IDX_W-1:0] ex_dr,
    input  logic                 branch_enable,
    output logic                 gen_bubble,
    output logic                 squash_id,
    output logic                 in_shadow,
    output logic [PERF_W-1:0]    perf_bubbles,
    output logic [PERF_W-1:0]    perf_squashes
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHADOW  = 2'd1,
        RESOLVE = 2'd2
    } state_t;

    localparam logic [2:0] SH_INIT   = 3'(BRANCH_SHADOW);
    localparam logic [1:0] LU_INIT   = 2'(LOAD_USE_BUBBLES - 1);
    localparam logic [2:0] LATE_INIT = 3'(LATE_LAT);
    localparam bit         LU_EN     = (LOAD_USE_BUBBLES > 0);
    localparam bit         SB_EN     = (LATE_LAT > 0);
    localparam bit         SH_MULTI  = (BRANCH_SHADOW > 1);

    state_t     state_q, state_d;
    logic [2:0] sh_cnt_q, sh_cnt_d;
    logic [1:0] lu_cnt_q, lu_cnt_d;
    logic       is_br_q, is_br_d;
    logic       taken_q;
    logic [2:0] pend_q [NUM_REGS];

    logic lu_match, sb_match;
    logic lu_hazard, sb_hazard, hz_bubble;
    logic bubble_i, squash_i, sb_write;

    // Source comparison against the load destination and the late-writeback scoreboard.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        lu_match = 1'b0;
        sb_match = 1'b0;
        if (id_sr1_v) begin
            lu_match = lu_match | (id_sr1 == ex_dr);
            sb_match = sb_match | (pend_q[id_sr1] != 3'd0);
        end
        if (id_sr2_v) begin
            lu_match = lu_match | (id_sr2 == ex_dr);
            sb_match = sb_match | (pend_q[id_sr2] != 3'd0);
        end
        if (id_sr3_v) begin
            lu_match = lu_match | (id_sr3 == ex_dr);
            sb_match = sb_match | (pend_q[id_sr3] != 3'd0);
        end
    end

    assign lu_hazard = LU_EN && (state_q == IDLE) && (lu_cnt_q == 2'd0) && id_valid &&
                       ex_load && ex_dr_v && lu_match;
    assign sb_hazard = SB_EN && (state_q == IDLE) && id_valid && sb_match;
    assign hz_bubble = lu_hazard || sb_hazard || (lu_cnt_q != 2'd0);

    assign bubble_i = (state_q == SHADOW) || hz_bubble;
    assign squash_i = (state_q == RESOLVE) && (!is_br_q || taken_q);
    assign sb_write = SB_EN && !bubble_i && !squash_i && id_valid && id_late_wr;

    // Outputs are forced low while reset is held, whatever the decode inputs show.
    assign gen_bubble = rst_n && bubble_i;
    assign squash_id  = rst_n && squash_i;
    assign in_shadow  = rst_n && (state_q != IDLE);

    always_comb begin
        state_d  = state_q;
        sh_cnt_d = sh_cnt_q;
        is_br_d  = is_br_q;
        lu_cnt_d = lu_cnt_q;
        case (state_q)
            IDLE: begin
                if (id_valid && id_ctrl_xfer && !hz_bubble) begin
                    sh_cnt_d = SH_INIT;
                    is_br_d  = id_is_br;
                    state_d  = SH_MULTI ? SHADOW : RESOLVE;
                end
            end
            SHADOW: begin
                sh_cnt_d = sh_cnt_q - 3'd1;
                if (sh_cnt_q == 3'd2) state_d = RESOLVE;
            end
            RESOLVE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (lu_hazard)                lu_cnt_d = LU_INIT;
        else if (lu_cnt_q != 2'd0)    lu_cnt_d = lu_cnt_q - 2'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sh_cnt_q <= 3'd0;
            lu_cnt_q <= 2'd0;
            is_br_q  <= 1'b0;
            taken_q  <= 1'b0;
        end else if (flow) begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q  <= state_d;
            sh_cnt_q <= sh_cnt_d;
            lu_cnt_q <= lu_cnt_d;
            is_br_q  <= is_br_d;
            taken_q  <= branch_enable;
        end
    end

    // Late-writeback scoreboard; a new load of an entry overrides its own countdown.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: this small register array is explicitly reset; pending counts must start clear.
            for (int r = 0; r < NUM_REGS; r++) pend_q[r] <= 3'd0;
        end else if (flow) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (pend_q[r] != 3'd0) pend_q[r] <= pend_q[r] - 3'd1;
            end
            if (sb_write) pend_q[id_dr] <= LATE_INIT;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [PERF_W-1:0] perf_bub_q, perf_sq_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_bub_q <= '0;
            perf_sq_q  <= '0;
        end else if (flow) begin
            if (bubble_i && !(&perf_bub_q)) perf_bub_q <= perf_bub_q + PERF_W'(1);
            if (squash_i && !(&perf_sq_q))  perf_sq_q  <= perf_sq_q + PERF_W'(1);
        end
    end

    assign perf_bubbles  = perf_bub_q;
    assign perf_squashes = perf_sq_q;
`else
    assign perf_bubbles  = '0;
    assign perf_squashes = '0;
`endif

endmodule

// File: tb/tb_hazard_sequencer.sv
// Scoreboard bench for hazard_sequencer: two instances (default config and BRANCH_SHADOW=1,
// LOAD_USE_BUBBLES=3, LATE_LAT=0) share stimulus; a negedge monitor checks queued expectations.
`timescale 1ns/1ps
module tb_hazard_sequencer;

    localparam int W  = 3;
    localparam int PW = 32;

    logic          clk;
    logic          rst_n;
    logic          flow;
    logic          id_valid;
    logic          id_sr1_v, id_sr2_v, id_sr3_v;
    logic [W-1:0]  id_sr1, id_sr2, id_sr3;
    logic          id_ctrl_xfer, id_is_br, id_late_wr;
    logic [W-1:0]  id_dr;
    logic          ex_load, ex_dr_v;
    logic [W-1:0]  ex_dr;
    logic          branch_enable;

    logic          gen_bubble_a, squash_id_a, in_shadow_a;
    logic [PW-1:0] perf_bubbles_a, perf_squashes_a;
    logic          gen_bubble_b, squash_id_b, in_shadow_b;
    logic [PW-1:0] perf_bubbles_b, perf_squashes_b;

    hazard_sequencer u_dut_a (
        .clk(clk), .rst_n(rst_n), .flow(flow), .id_valid(id_valid),
        .id_sr1_v(id_sr1_v), .id_sr2_v(id_sr2_v), .id_sr3_v(id_sr3_v),
        .id_sr1(id_sr1), .id_sr2(id_sr2), .id_sr3(id_sr3),
        .id_ctrl_xfer(id_ctrl_xfer), .id_is_br(id_is_br), .id_late_wr(id_late_wr),
        .id_dr(id_dr), .ex_load(ex_load), .ex_dr_v(ex_dr_v), .ex_dr(ex_dr),
        .branch_enable(branch_enable),
        .gen_bubble(gen_bubble_a), .squash_id(squash_id_a), .in_shadow(in_shadow_a),
        .perf_bubbles(perf_bubbles_a), .perf_squashes(perf_squashes_a)
    );

    hazard_sequencer #(
        .BRANCH_SHADOW(1), .LOAD_USE_BUBBLES(3), .LATE_LAT(0)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n), .flow(flow), .id_valid(id_valid),
        .id_sr1_v(id_sr1_v), .id_sr2_v(id_sr2_v), .id_sr3_v(id_sr3_v),
        .id_sr1(id_sr1), .id_sr2(id_sr2), .id_sr3(id_sr3),
        .id_ctrl_xfer(id_ctrl_xfer), .id_is_br(id_is_br), .id_late_wr(id_late_wr),
        .id_dr(id_dr), .ex_load(ex_load), .ex_dr_v(ex_dr_v), .ex_dr(ex_dr),
        .branch_enable(branch_enable),
        .gen_bubble(gen_bubble_b), .squash_id(squash_id_b), .in_shadow(in_shadow_b),
        .perf_bubbles(perf_bubbles_b), .perf_squashes(perf_squashes_b)
    );

    typedef struct {
        string       name;
        bit          sel;      // 0 = u_dut_a, 1 = u_dut_b
        bit          is_perf;
        logic [2:0]  outs;     // {gen_bubble, squash_id, in_shadow}
        logic [31:0] pb;
        logic [31:0] ps;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [2:0]  act_outs;
    logic [31:0] act_pb, act_ps;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run did not complete, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

    // Monitor: drains all expectations queued for this cycle, away from the rising edge.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            n_checks++;
            if (mon_e.is_perf) begin
                act_pb = mon_e.sel ? perf_bubbles_b  : perf_bubbles_a;
                act_ps = mon_e.sel ? perf_squashes_b : perf_squashes_a;
                if (act_pb !== mon_e.pb || act_ps !== mon_e.ps) begin
                    n_errors++;
                    $display("FAIL %s: perf_bubbles=%0d perf_squashes=%0d, expected %0d %0d",
                             mon_e.name, act_pb, act_ps, mon_e.pb, mon_e.ps);
                end
            end else begin
                act_outs = mon_e.sel ? {gen_bubble_b, squash_id_b, in_shadow_b}
                                     : {gen_bubble_a, squash_id_a, in_shadow_a};
                if (act_outs !== mon_e.outs) begin
                    n_errors++;
                    $display("FAIL %s: {gen_bubble,squash_id,in_shadow}=%b, expected %b",
                             mon_e.name, act_outs, mon_e.outs);
                end
            end
        end
    end

    task automatic idle_inputs();
        flow = 1'b1; id_valid = 1'b0;
        id_sr1_v = 1'b0; id_sr2_v = 1'b0; id_sr3_v = 1'b0;
        id_sr1 = '0; id_sr2 = '0; id_sr3 = '0;
        id_ctrl_xfer = 1'b0; id_is_br = 1'b0; id_late_wr = 1'b0; id_dr = '0;
        ex_load = 1'b0; ex_dr_v = 1'b0; ex_dr = '0; branch_enable = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_out(input string name, input bit sel, input bit g, input bit s, input bit sh);
        exp_t e;
        e.name = name; e.sel = sel; e.is_perf = 1'b0;
        e.outs = {g, s, sh}; e.pb = '0; e.ps = '0;
        exp_q.push_back(e);
    endtask

    task automatic expect_out(input string name, input bit sel, input bit g, input bit s, input bit sh);
        push_out(name, sel, g, s, sh);
        tick();
    endtask

    task automatic expect_perf(input string name, input int pb, input int ps);
        exp_t e;
        e.name = name; e.sel = 1'b0; e.is_perf = 1'b1; e.outs = '0;
`ifdef HAZARD_PERF_EN
        e.pb = 32'(pb); e.ps = 32'(ps);
`else
        e.pb = '0; e.ps = '0;
`endif
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Hazardous decode inputs while reset is held: outputs must stay 0.
        id_valid = 1; id_sr1_v = 1; id_sr1 = 3; ex_load = 1; ex_dr_v = 1; ex_dr = 3; id_ctrl_xfer = 1;
        expect_perf("rst_perf", 0, 0);
        push_out("rst_out_b", 1, 0, 0, 0);
        expect_out("rst_out_a", 0, 0, 0, 0);
        idle_inputs();
        rst_n = 1'b1;

        // Load-use on instance A (one bubble)
        id_valid = 1; id_sr1_v = 1; id_sr1 = 3; ex_load = 1; ex_dr_v = 1; ex_dr = 3;
        expect_out("lu_bubble", 0, 1, 0, 0);
        ex_load = 0; ex_dr_v = 0;
        expect_out("lu_release", 0, 0, 0, 0);
        id_sr1 = 4; id_sr2_v = 0; id_sr2 = 3; ex_load = 1; ex_dr_v = 1; ex_dr = 3;
        expect_out("lu_nomatch", 0, 0, 0, 0);
        id_sr3_v = 1; id_sr3 = 3;
        expect_out("lu_sr3", 0, 1, 0, 0);
        ex_load = 0; ex_dr_v = 0;
        expect_out("lu_sr3_release", 0, 0, 0, 0);
        ex_load = 1; ex_dr_v = 0;
        expect_out("lu_no_dest", 0, 0, 0, 0);

        // Conditional branch, taken: 3 shadow bubbles then a squashing resolve
        do_reset();
        id_valid = 1; id_ctrl_xfer = 1; id_is_br = 1;
        expect_out("br_accept", 0, 0, 0, 0);
        id_ctrl_xfer = 0; id_is_br = 0;
        expect_out("br_sh1", 0, 1, 0, 1);
        expect_out("br_sh2", 0, 1, 0, 1);
        branch_enable = 1;
        expect_out("br_sh3", 0, 1, 0, 1);
        branch_enable = 0;
        expect_out("br_taken_resolve", 0, 0, 1, 1);
        expect_perf("br_taken_perf", 3, 1);
        expect_out("br_idle", 0, 0, 0, 0);

        // Conditional branch, not taken
        id_ctrl_xfer = 1; id_is_br = 1;
        expect_out("brn_accept", 0, 0, 0, 0);
        id_ctrl_xfer = 0; id_is_br = 0;
        for (int i = 0; i < 3; i++) expect_out("brn_shadow", 0, 1, 0, 1);
        expect_out("brn_resolve", 0, 0, 0, 1);
        expect_perf("brn_perf", 6, 1);
        expect_out("brn_idle", 0, 0, 0, 0);

        // Flow stall mid-shadow: state, bubble and taken latch all held
        id_ctrl_xfer = 1; id_is_br = 1;
        expect_out("hold_accept", 0, 0, 0, 0);
        id_ctrl_xfer = 0; id_is_br = 0;
        expect_out("hold_sh4", 0, 1, 0, 1);
        flow = 0; branch_enable = 1;
        for (int i = 0; i < 4; i++) expect_out("hold_flow0", 0, 1, 0, 1);
        flow = 1; branch_enable = 0;
        expect_out("hold_sh3", 0, 1, 0, 1);
        expect_out("hold_sh2", 0, 1, 0, 1);
        expect_out("hold_resolve", 0, 0, 0, 1);
        expect_perf("hold_perf", 9, 1);
        expect_out("hold_idle", 0, 0, 0, 0);

        // Asynchronous reset in the middle of a shadow
        id_ctrl_xfer = 1; id_is_br = 1;
        expect_out("rst_accept", 0, 0, 0, 0);
        id_ctrl_xfer = 0; id_is_br = 0; branch_enable = 1;
        expect_out("rst_sh", 0, 1, 0, 1);
        rst_n = 1'b0;
        expect_perf("rst_mid_perf", 0, 0);
        expect_out("rst_mid", 0, 0, 0, 0);
        rst_n = 1'b1; branch_enable = 0;
        expect_out("rst_after", 0, 0, 0, 0);

        // Late-writeback scoreboard on instance A (LATE_LAT=2)
        idle_inputs();
        id_valid = 1; id_late_wr = 1; id_dr = 2;
        expect_out("lea_r2", 0, 0, 0, 0);
        id_late_wr = 0; id_sr1_v = 1; id_sr1 = 2;
        expect_out("sb_r2_b1", 0, 1, 0, 0);
        expect_out("sb_r2_b2", 0, 1, 0, 0);
        expect_out("sb_r2_go", 0, 0, 0, 0);
        id_sr1_v = 0; id_late_wr = 1; id_dr = 2;
        expect_out("lea_r2_again", 0, 0, 0, 0);
        id_late_wr = 0; id_sr2_v = 1; id_sr2 = 5;
        expect_out("sb_r5", 0, 0, 0, 0);
        id_sr2 = 2;
        expect_out("sb_r2_late", 0, 1, 0, 0);
        expect_out("sb_r2_clear", 0, 0, 0, 0);

        // JMP through a pending register waits, then squashes; squashed LEA never writes
        id_sr2_v = 0; id_late_wr = 1; id_dr = 2;
        expect_out("lea_r2_jmp", 0, 0, 0, 0);
        id_late_wr = 0; id_ctrl_xfer = 1; id_is_br = 0; id_sr1_v = 1; id_sr1 = 2;
        expect_out("jmp_wait1", 0, 1, 0, 0);
        expect_out("jmp_wait2", 0, 1, 0, 0);
        expect_out("jmp_accept", 0, 0, 0, 0);
        id_ctrl_xfer = 0; id_sr1_v = 0; id_late_wr = 1; id_dr = 6;
        for (int i = 0; i < 3; i++) expect_out("jmp_shadow", 0, 1, 0, 1);
        expect_out("jmp_resolve", 0, 0, 1, 1);
        id_late_wr = 0; id_sr1_v = 1; id_sr1 = 6;
        expect_out("sb_squash_nowr", 0, 0, 0, 0);

        // Instance B: BRANCH_SHADOW=1, LOAD_USE_BUBBLES=3, LATE_LAT=0
        do_reset();
        id_valid = 1; id_ctrl_xfer = 1; id_is_br = 0;
        expect_out("b_jmp_accept", 1, 0, 0, 0);
        id_ctrl_xfer = 0;
        expect_out("b_jmp_resolve", 1, 0, 1, 1);
        expect_out("b_idle", 1, 0, 0, 0);
        id_ctrl_xfer = 1; id_is_br = 1; branch_enable = 0;
        expect_out("b_brn_accept", 1, 0, 0, 0);
        id_ctrl_xfer = 0; id_is_br = 0;
        expect_out("b_brn_resolve", 1, 0, 0, 1);
        id_ctrl_xfer = 1; id_is_br = 1; branch_enable = 1;
        expect_out("b_brt_accept", 1, 0, 0, 0);
        id_ctrl_xfer = 0; id_is_br = 0; branch_enable = 0;
        expect_out("b_brt_resolve", 1, 0, 1, 1);
        id_sr1_v = 1; id_sr1 = 3; ex_load = 1; ex_dr_v = 1; ex_dr = 3;
        expect_out("b_lu1", 1, 1, 0, 0);
        ex_load = 0; ex_dr_v = 0;
        expect_out("b_lu2", 1, 1, 0, 0);
        expect_out("b_lu3", 1, 1, 0, 0);
        expect_out("b_lu_go", 1, 0, 0, 0);
        id_sr1_v = 0; id_late_wr = 1; id_dr = 2;
        expect_out("b_lea", 1, 0, 0, 0);
        id_late_wr = 0; id_sr1_v = 1; id_sr1 = 2;
        expect_out("b_no_sb", 1, 0, 0, 0);

        idle_inputs();
        repeat (2) tick();
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hazard_sequencer.md
Name: hazard_sequencer

Overview:
- Parametrised pipeline hazard controller for the LC-3b pipeline; sits between IF/ID and ID/EX.
- Issues bubbles for load-use hazards, control-transfer shadows and late-writeback (LEA-style) register dependencies.
- Squashes the decode instruction when a control transfer resolves taken.
- Generalises the fixed-count branch and load bubbler: configurable shadow depth, load-use depth and per-register late-writeback scoreboard.

Parameters:
- REG_IDX_W, 3, register index width.
- NUM_REGS, 8, scoreboard entries (2**REG_IDX_W).
- BRANCH_SHADOW, 4, control-transfer shadow length in flow cycles; legal 1..7.
- LOAD_USE_BUBBLES, 1, bubbles per load-use hazard; legal 0..3; 0 disables detection.
- LATE_LAT, 2, late-writeback pending cycles; legal 0..7; 0 disables scoreboard.
- PERF_W, 32, perf counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flow  in  1  pipeline advances this cycle; all state updates are gated by it.
- id_valid  in  1  IF/ID holds a real instruction.
- id_sr1_v/id_sr2_v/id_sr3_v  in  1 each  decode source needed (sr3 = store source, IR[11:9]).
- id_sr1/id_sr2/id_sr3  in  REG_IDX_W each  source indices.
- id_ctrl_xfer  in  1  decode instruction is BR/JMP/JSR/TRAP.
- id_is_br  in  1  conditional BR (others unconditional).
- id_late_wr  in  1  decode instruction writes its destination late (e.g. LEA).
- id_dr  in  REG_IDX_W  decode destination.
- ex_load  in  1  ID/EX holds LDR/LDB/LDI.
- ex_dr_v  in  1  ID/EX writes a destination.
- ex_dr  in  REG_IDX_W  ID/EX destination.
- branch_enable  in  1  branch condition result.
- gen_bubble  out  1  hold IF/ID, inject NOP into ID/EX.
- squash_id  out  1  replace IF/ID instruction with NOP.
- in_shadow  out  1  FSM in SHADOW or RESOLVE.
- perf_bubbles  out  PERF_W  bubble count.
- perf_squashes  out  PERF_W  squash count.

Behaviour:
- Reset: all counters, scoreboard, taken latch and perf counters are 0; FSM goes to IDLE. All outputs are 0 while rst_n is low.
- Outputs are combinational from state and inputs. State is held when flow=0.
- taken_q loads branch_enable on every flow cycle.

FSM:
- IDLE: on flow and id_valid and id_ctrl_xfer and no hazard bubble, load sh_cnt=BRANCH_SHADOW and latch is_br_q=id_is_br. Next state is SHADOW if BRANCH_SHADOW>1, else RESOLVE.
- SHADOW: gen_bubble=1 and hazard detection is suppressed. On flow, sh_cnt decrements; at sh_cnt==2 the next state is RESOLVE.
- RESOLVE: no bubble. squash_id = !is_br_q or taken_q. On flow, next state is IDLE.
- Result: exactly BRANCH_SHADOW-1 bubbles, then one resolve cycle.

Load-use:
- In IDLE with lu_cnt==0: hazard if id_valid, ex_load, ex_dr_v, LOAD_USE_BUBBLES>0, and any valid source equals ex_dr. Hazard gives gen_bubble=1.
- On flow, lu_cnt loads LOAD_USE_BUBBLES-1.
- While lu_cnt>0: gen_bubble=1; decrements on flow.

Scoreboard:
- pend[r], 3 bits per register.
- Hazard if id_valid and any valid source s has pend[s]!=0. Hazard gives gen_bubble=1 (IDLE only).
- Every flow cycle, nonzero entries decrement.
- On flow with gen_bubble=0, squash_id=0, id_valid and id_late_wr: pend[id_dr] loads LATE_LAT. The load wins over the same-cycle decrement.
- Entries keep counting during SHADOW.

Priority and edge cases:
- A control transfer with a pending hazard bubbles first and is accepted only once hazard-free.
- An instruction whose squash_id=1 never writes the scoreboard or starts a shadow.
- A reset assertion mid-shadow or mid-count returns to IDLE immediately (asynchronous).

Optional Feature:
- Macro HAZARD_PERF_EN.
- Defined: perf_bubbles increments on each flow cycle with gen_bubble=1; perf_squashes increments on each flow cycle with squash_id=1. Both saturate at all-ones and reset to 0.
- Undefined: no counter registers; both ports tied to 0.

Test Plan:
- ex_load=1, ex_dr=3; id ADD with sr1=3; LOAD_USE_BUBBLES=1; flow=1 -> gen_bubble=1 for one cycle, then 0. With LOAD_USE_BUBBLES=3 -> 3 consecutive bubbles.
- BR, BRANCH_SHADOW=4, branch_enable=1 on the cycle before resolve -> bubbles on cycles T+1..T+3, squash_id=1 at T+4. Repeat with branch_enable=0 -> squash_id=0.
- JMP, BRANCH_SHADOW=1 -> no bubbles; squash_id=1 at T+1 regardless of branch_enable.
- LEA R2 (id_late_wr) at T, LATE_LAT=2; ADD reading R2 at T+1 -> gen_bubble=1 at T+1 and T+2, 0 at T+3. Reader of R5 -> no bubble.
- In SHADOW with sh_cnt=3: flow=0 for 4 cycles -> state and gen_bubble held. Then pulse rst_n=0 mid-shadow -> gen_bubble, squash_id, in_shadow all 0 asynchronously.
- HAZARD_PERF_EN defined, BR taken with BRANCH_SHADOW=4 -> perf_bubbles=3, perf_squashes=1. Undefined -> both read 0.
